// File: rtl/decode_pkg.sv
// Shared decode/encode definitions: immediate-type codes and datapath widths.
// Used by the immediate extender and by imm_pack.
package decode_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IMM_SRC_W = 4;
  localparam int unsigned ERR_W     = 8;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 4'd0,
    IMM_S = 4'd1,
    IMM_B = 4'd2,
    IMM_J = 4'd3,
    IMM_U = 4'd4
  } imm_src_t;

endpackage

// File: rtl/imm_pack_if.sv
// Handshake and payload bundle for imm_pack: input word channel, packed output
// channel, and the write-address / error-count status.
interface imm_pack_if
  import decode_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned ERRW  = ERR_W
);

  logic                 InValid;
  logic                 InReady;
  logic [IMM_SRC_W-1:0] ImmSrc;
  logic [WIDTH-1:0]     ImmVal;
  logic [WIDTH-1:0]     Base;
  logic                 OutValid;
  logic                 OutReady;
  logic [WIDTH-1:0]     Instr;
  logic                 ImmErr;
  logic [WIDTH-1:0]     WrAddr;
  logic [ERRW-1:0]      ErrCount;

  modport master (
    output InValid, ImmSrc, ImmVal, Base, OutReady,
    input  InReady, OutValid, Instr, ImmErr, WrAddr, ErrCount
  );

  modport slave (
    input  InValid, ImmSrc, ImmVal, Base, OutReady,
    output InReady, OutValid, Instr, ImmErr, WrAddr, ErrCount
  );

endinterface

// File: rtl/imm_pack_field.sv
// Combinational immediate packer: scatters ImmVal into the RV32I bit positions
// for the given type over a base word, and flags unrepresentable immediates.
module imm_pack_field
  import decode_pkg::*;
(
  input  logic [IMM_SRC_W-1:0] imm_src,
  input  logic [XLEN-1:0]      imm_val,
  input  logic [XLEN-1:0]      base,
  output logic [XLEN-1:0]      instr_c,
  output logic                 imm_err_c
);

  // Sign-extension checks: upper bits must be all zeros or all ones.
  logic sext_11_c;
  logic sext_12_c;
  logic sext_20_c;

  assign sext_11_c = (&imm_val[31:11]) || !(|imm_val[31:11]);
  assign sext_12_c = (&imm_val[31:12]) || !(|imm_val[31:12]);
  assign sext_20_c = (&imm_val[31:20]) || !(|imm_val[31:20]);

  always_comb begin
    instr_c   = base;
    imm_err_c = 1'b0;
    case (imm_src)
      IMM_I: begin
        instr_c[31:20] = imm_val[11:0];
        imm_err_c      = !sext_11_c;
      end
      IMM_S: begin
        instr_c[31:25] = imm_val[11:5];
        instr_c[11:7]  = imm_val[4:0];
        imm_err_c      = !sext_11_c;
      end
      IMM_B: begin
        instr_c[31]    = imm_val[12];
        instr_c[30:25] = imm_val[10:5];
        instr_c[11:8]  = imm_val[4:1];
        instr_c[7]     = imm_val[11];
        imm_err_c      = !sext_12_c || imm_val[0];
      end
      IMM_J: begin
        instr_c[31]    = imm_val[20];
        instr_c[30:21] = imm_val[10:1];
        instr_c[20]    = imm_val[11];
        instr_c[19:12] = imm_val[19:12];
        imm_err_c      = !sext_20_c || imm_val[0];
      end
      IMM_U: begin
        instr_c[31:12] = imm_val[31:12];
        imm_err_c      = |imm_val[11:0];
      end
      default: imm_err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_pack.sv
// Two-stage valid/ready immediate packer with instruction-memory write address
// tracking and a saturating count of words shipped with ImmErr set.
module imm_pack
  import decode_pkg::*;
#(
  parameter int unsigned      WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned      ERRW      = ERR_W
)(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     Clear,
  imm_pack_if.slave bus
);

  logic                 s1_valid_q, s1_valid_d;
  logic [IMM_SRC_W-1:0] s1_src_q,   s1_src_d;
  logic [WIDTH-1:0]     s1_imm_q,   s1_imm_d;
  logic [WIDTH-1:0]     s1_base_q,  s1_base_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     instr_q,    instr_d;
  logic                 imm_err_q,  imm_err_d;
  logic [WIDTH-1:0]     wr_addr_q,  wr_addr_d;
  logic [ERRW-1:0]      err_count_q, err_count_d;

  logic             adv1_c, adv2_c, in_xfer_c, out_xfer_c;
  logic [WIDTH-1:0] pack_instr_c;
  logic             pack_err_c;

  assign adv2_c     = !out_valid_q || bus.OutReady;
  assign adv1_c     = !s1_valid_q || adv2_c;
  assign in_xfer_c  = bus.InValid && adv1_c;
  assign out_xfer_c = out_valid_q && bus.OutReady;

  imm_pack_field u_field (
    .imm_src   (s1_src_q),
    .imm_val   (s1_imm_q),
    .base      (s1_base_q),
    .instr_c   (pack_instr_c),
    .imm_err_c (pack_err_c)
  );

  // Pipeline advance, address/error bookkeeping; Clear overrides any transfer.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_src_d    = s1_src_q;
    s1_imm_d    = s1_imm_q;
    s1_base_d   = s1_base_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    imm_err_d   = imm_err_q;
    wr_addr_d   = wr_addr_q;
    err_count_d = err_count_q;

    if (Clear) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      wr_addr_d   = BASE_ADDR;
      err_count_d = '0;
    end else begin
      if (adv1_c) begin
        s1_valid_d = bus.InValid;
      end
      if (in_xfer_c) begin
        s1_src_d  = bus.ImmSrc;
        s1_imm_d  = bus.ImmVal;
        s1_base_d = bus.Base;
      end
      if (adv2_c) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          instr_d   = pack_instr_c;
          imm_err_d = pack_err_c;
        end
      end
      if (out_xfer_c) begin
        wr_addr_d = wr_addr_q + WIDTH'(4);
        if (imm_err_q && (err_count_q != '1)) begin
          err_count_d = err_count_q + ERRW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_src_q    <= '0;
      s1_imm_q    <= '0;
      s1_base_q   <= '0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      imm_err_q   <= 1'b0;
      wr_addr_q   <= BASE_ADDR;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_src_q    <= s1_src_d;
      s1_imm_q    <= s1_imm_d;
      s1_base_q   <= s1_base_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      imm_err_q   <= imm_err_d;
      wr_addr_q   <= wr_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.InReady  = adv1_c;
  assign bus.OutValid = out_valid_q;
  assign bus.Instr    = instr_q;
  assign bus.ImmErr   = imm_err_q;
  assign bus.WrAddr   = wr_addr_q;
  assign bus.ErrCount = err_count_q;

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: directed plan steps, randomized traffic
// against an arithmetic reference model, stall-hold and saturation checks.
module tb_imm_pack;
  import decode_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk;
  logic rst_n;
  logic Clear;

  imm_pack_if #(.WIDTH(32), .ERRW(8)) bus ();

  imm_pack #(.WIDTH(32), .BASE_ADDR(BASE), .ERRW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Clear (Clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: field placement by shifts/masks, range by signed bounds.
  function automatic logic [32:0] model(input logic [3:0] s, input logic [31:0] v,
                                        input logic [31:0] b);
    int          sv;
    logic [31:0] ins;
    logic        e;
    sv = $signed(v);
    case (s)
      4'd0: begin
        ins = (b & 32'h000F_FFFF) | ((v & 32'hFFF) << 20);
        e   = (sv < -2048) || (sv > 2047);
      end
      4'd1: begin
        ins = (b & 32'h01FF_F07F) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
        e   = (sv < -2048) || (sv > 2047);
      end
      4'd2: begin
        ins = (b & 32'h01FF_F07F) | (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25)
            | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7);
        e   = (sv < -4096) || (sv > 4095) || ((v % 2) != 0);
      end
      4'd3: begin
        ins = (b & 32'h0000_0FFF) | (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
            | (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12);
        e   = (sv < -1048576) || (sv > 1048575) || ((v % 2) != 0);
      end
      4'd4: begin
        ins = (v & 32'hFFFF_F000) | (b & 32'h0000_0FFF);
        e   = (v % 4096) != 0;
      end
      default: begin
        ins = b;
        e   = 1'b1;
      end
    endcase
    return {e, ins};
  endfunction

  // Scoreboard monitor: samples at negedge, away from the active edge.
  logic [32:0] q[$];
  logic [31:0] exp_addr;
  int          exp_ec;
  logic        hold_v;
  logic [31:0] hold_instr, hold_addr;
  logic        hold_err;

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      q.delete();
      exp_addr = BASE;
      exp_ec   = 0;
      hold_v   = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 32'(bus.OutValid), 32'd1);
        chk("hold_instr", bus.Instr, hold_instr);
        chk("hold_err",   32'(bus.ImmErr), 32'(hold_err));
        chk("hold_addr",  bus.WrAddr, hold_addr);
      end
      chk("err_count", 32'(bus.ErrCount), 32'(exp_ec));
      if (Clear) begin
        q.delete();
        exp_addr = BASE;
        exp_ec   = 0;
        hold_v   = 1'b0;
      end else begin
        hold_v     = bus.OutValid && !bus.OutReady;
        hold_instr = bus.Instr;
        hold_err   = bus.ImmErr;
        hold_addr  = bus.WrAddr;
        if (bus.OutValid && bus.OutReady) begin
          chk("out_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_instr", bus.Instr, e[31:0]);
            chk("sb_err",   32'(bus.ImmErr), 32'(e[32]));
            chk("sb_addr",  bus.WrAddr, exp_addr);
            exp_addr = exp_addr + 32'd4;
            if (e[32] && exp_ec != 255) exp_ec++;
          end
        end
        if (bus.InValid && bus.InReady) q.push_back(model(bus.ImmSrc, bus.ImmVal, bus.Base));
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] s, input logic [31:0] v, input logic [31:0] b);
    bus.InValid = 1'b1;
    bus.ImmSrc  = s;
    bus.ImmVal  = v;
    bus.Base    = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.InReady) begin
        @(posedge clk); #1;
        bus.InValid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 32'd1, 32'd0);
    bus.InValid = 1'b0;
  endtask

  // Waits (bounded) for OutValid at a negedge.
  task automatic wait_out();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.OutValid) return;
    end
    chk("out_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          t;
    int          r;
    logic [31:0] v;

    rst_n        = 1'b0;
    Clear        = 1'b0;
    bus.InValid  = 1'b0;
    bus.ImmSrc   = '0;
    bus.ImmVal   = '0;
    bus.Base     = '0;
    bus.OutReady = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
    chk("rst_instr",    bus.Instr, 32'd0);
    chk("rst_immerr",   32'(bus.ImmErr), 32'd0);
    chk("rst_wraddr",   bus.WrAddr, BASE);
    chk("rst_errcount", 32'(bus.ErrCount), 32'd0);
    chk("rst_inready",  32'(bus.InReady), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_inready", 32'(bus.InReady), 32'd1);
    @(posedge clk); #1;

    // I-type, latency and address step
    send(IMM_I, 32'hFFFF_F800, 32'h0000_0013);
    @(negedge clk);
    chk("lat_not_yet", 32'(bus.OutValid), 32'd0);
    @(negedge clk);
    chk("lat_valid",  32'(bus.OutValid), 32'd1);
    chk("i_instr",    bus.Instr, 32'h8000_0013);
    chk("i_err",      32'(bus.ImmErr), 32'd0);
    chk("i_wraddr",   bus.WrAddr, 32'h0);
    @(negedge clk);
    chk("i_wraddr_next", bus.WrAddr, 32'h4);
    @(posedge clk); #1;

    // I-type out of range
    send(IMM_I, 32'h0000_0800, 32'h0000_0013);
    wait_out();
    chk("i_oor_instr", bus.Instr, 32'h8000_0013);
    chk("i_oor_err",   32'(bus.ImmErr), 32'd1);
    @(posedge clk); #1;
    chk("i_oor_errcount", 32'(bus.ErrCount), 32'd1);

    send(IMM_B, 32'h0000_0010, 32'h0000_0063);
    wait_out();
    chk("b_instr", bus.Instr, 32'h0000_0863);
    chk("b_err",   32'(bus.ImmErr), 32'd0);
    @(posedge clk); #1;

    send(IMM_J, 32'h0000_0800, 32'h0000_006F);
    wait_out();
    chk("j_instr", bus.Instr, 32'h0010_006F);
    @(posedge clk); #1;

    send(IMM_U, 32'h1234_5000, 32'h0000_0037);
    wait_out();
    chk("u_instr", bus.Instr, 32'h1234_5037);
    chk("u_err",   32'(bus.ImmErr), 32'd0);
    @(posedge clk); #1;

    send(IMM_U, 32'h1234_5001, 32'h0000_0037);
    wait_out();
    chk("u_oor_err",   32'(bus.ImmErr), 32'd1);
    chk("u_oor_instr", bus.Instr, 32'h1234_5037);
    @(posedge clk); #1;
    idle(2);

    // Five-word stream with a 3-cycle downstream stall
    Clear = 1'b1;
    idle(1);
    Clear = 1'b0;
    bus.OutReady = 1'b0;
    send(IMM_I, 32'h1, 32'h13);
    send(IMM_I, 32'h2, 32'h13);
    bus.InValid = 1'b1;
    bus.ImmSrc  = IMM_I;
    bus.ImmVal  = 32'h3;
    bus.Base    = 32'h13;
    @(negedge clk);
    chk("stall_inready", 32'(bus.InReady), 32'd0);
    @(posedge clk); #1;
    bus.OutReady = 1'b1;
    send(IMM_I, 32'h3, 32'h13);
    send(IMM_S, 32'h4, 32'h23);
    send(IMM_B, 32'hFFFF_FFFC, 32'h63);
    idle(6);
    chk("stream_wraddr",   bus.WrAddr, 32'h14);
    chk("stream_drained",  32'(q.size()), 32'd0);
    chk("stream_errcount", 32'(bus.ErrCount), 32'd0);

    // Reset with words in flight
    bus.OutReady = 1'b0;
    send(IMM_I, 32'h5, 32'h13);
    send(IMM_I, 32'h6, 32'h13);
    rst_n = 1'b0;
    #1;
    chk("midrst_outvalid", 32'(bus.OutValid), 32'd0);
    chk("midrst_wraddr",   bus.WrAddr, BASE);
    chk("midrst_inready",  32'(bus.InReady), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.OutReady = 1'b1;
    idle(3);
    chk("midrst_no_ghost", 32'(bus.OutValid), 32'd0);

    // Randomized traffic with backpressure and a Clear pulse
    for (int i = 0; i < 600; i++) begin
      bus.OutReady = ($urandom % 4) != 0;
      bus.InValid  = ($urandom % 3) != 0;
      Clear        = (i == 300);
      bus.ImmSrc   = (($urandom % 16) == 0) ? 4'hF : 4'($urandom % 8);
      bus.Base     = $urandom;
      r = $urandom % 4;
      case (r)
        0: v = $urandom;
        1: begin t = int'($urandom_range(0, 8191)) - 4096;       v = 32'(t); end
        2: begin t = int'($urandom_range(0, 2097151)) - 1048576; v = 32'(t); end
        default: v = $urandom & 32'hFFFF_F000;
      endcase
      bus.ImmVal = v;
      @(posedge clk); #1;
    end
    bus.InValid  = 1'b0;
    Clear        = 1'b0;
    bus.OutReady = 1'b1;
    idle(5);
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Back-to-back illegal words: full throughput and counter saturation
    Clear = 1'b1;
    idle(1);
    Clear        = 1'b0;
    bus.InValid  = 1'b1;
    bus.ImmSrc   = 4'd7;
    bus.ImmVal   = 32'h0;
    bus.Base     = 32'hABCD_0013;
    idle(270);
    bus.InValid = 1'b0;
    idle(4);
    chk("sat_errcount", 32'(bus.ErrCount), 32'hFF);
    chk("sat_wraddr",   bus.WrAddr, 32'd1080);
    chk("sat_drained",  32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
